// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM port between requesters A and B.
// Optional per-requester grant counters are enabled with `define MEM_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqAValid,
  input  logic                  reqAWrite,
  input  logic [ADDR_WIDTH-1:0] reqAAddr,
  input  logic [DATA_WIDTH-1:0] reqAData,
  output logic                  reqAReady,
  output logic                  respAValid,
  output logic [DATA_WIDTH-1:0] respAData,
  input  logic                  reqBValid,
  input  logic                  reqBWrite,
  input  logic [ADDR_WIDTH-1:0] reqBAddr,
  input  logic [DATA_WIDTH-1:0] reqBData,
  output logic                  reqBReady,
  output logic                  respBValid,
  output logic [DATA_WIDTH-1:0] respBData,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memData,
  output logic                  memWE,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0]           grantCountA,
  output logic [15:0]           grantCountB,
`endif
  input  logic [DATA_WIDTH-1:0] memQ
);

  localparam int STAGES = 2;

  logic [1:0]                 req_vld, req_wr, gnt;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0] req_data;
  logic                       last_b;    // 1 = B held the most recent grant
  logic                       sel, acc, rd;
  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1]            own_pipe;  // 1 = read issued by B

  assign req_vld  = {reqBValid, reqAValid};
  assign req_wr   = {reqBWrite, reqAWrite};
  assign req_addr = {reqBAddr, reqAAddr};
  assign req_data = {reqBData, reqAData};

  // Grant is forced off while reset is held so no handshake can complete.
  always_comb begin
    gnt = '0;
    if (reset) begin
      if (req_vld[0] && (!req_vld[1] || last_b)) gnt[0] = 1'b1;
      else if (req_vld[1])                       gnt[1] = 1'b1;
    end
  end

  assign sel = gnt[1];
  assign acc = |gnt;
  assign rd  = acc & ~req_wr[sel];

  assign reqAReady = gnt[0];
  assign reqBReady = gnt[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memAddr  <= '0;
      memData  <= '0;
      memWE    <= 1'b0;
      last_b   <= 1'b1;
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      memWE <= acc & req_wr[sel];
      if (acc) begin
        memAddr <= req_addr[sel];
        memData <= req_data[sel];
        last_b  <= sel;
      end
      // Tag follows the read through the port register and the RAM's read register.
      vld_pipe <= {vld_pipe[STAGES-1:1], rd};
      own_pipe <= {own_pipe[STAGES-1:1], sel};
    end
  end

  assign respAValid = vld_pipe[STAGES] & ~own_pipe[STAGES];
  assign respBValid = vld_pipe[STAGES] &  own_pipe[STAGES];
  assign respAData  = memQ;
  assign respBData  = memQ;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] cnt_a, cnt_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (gnt[0] && cnt_a != 16'hFFFF) cnt_a <= cnt_a + 16'd1;
      if (gnt[1] && cnt_b != 16'hFFFF) cnt_b <= cnt_b + 16'd1;
    end
  end

  assign grantCountA = cnt_a;
  assign grantCountB = cnt_b;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a RAM model drives memQ, a monitor checks grants,
// the memory port and read responses against an independent golden memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reqAValid = 1'b0, reqAWrite = 1'b0;
  logic [11:0] reqAAddr = '0;
  logic [15:0] reqAData = '0;
  logic        reqAReady, respAValid;
  logic [15:0] respAData;
  logic        reqBValid = 1'b0, reqBWrite = 1'b0;
  logic [11:0] reqBAddr = '0;
  logic [15:0] reqBData = '0;
  logic        reqBReady, respBValid;
  logic [15:0] respBData;
  logic [11:0] memAddr;
  logic [15:0] memData;
  logic        memWE;
  logic [15:0] memQ;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] grantCountA, grantCountB;
`endif

  mem_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .reqAValid(reqAValid), .reqAWrite(reqAWrite), .reqAAddr(reqAAddr), .reqAData(reqAData),
    .reqAReady(reqAReady), .respAValid(respAValid), .respAData(respAData),
    .reqBValid(reqBValid), .reqBWrite(reqBWrite), .reqBAddr(reqBAddr), .reqBData(reqBData),
    .reqBReady(reqBReady), .respBValid(respBValid), .respBData(respBData),
    .memAddr(memAddr), .memData(memData), .memWE(memWE),
`ifdef MEM_ARB_STATS_EN
    .grantCountA(grantCountA), .grantCountB(grantCountB),
`endif
    .memQ(memQ)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // RAM with one-cycle synchronous read, plus the golden copy the scoreboard uses.
  logic [15:0] ram  [4096];
  logic [15:0] gold [4096];

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'(i * 3 + 7);
    ram[1]   = 16'h003A;
    ram[20]  = 16'h0042;
    ram[512] = 16'h0512;
    for (int i = 0; i < 4096; i++) gold[i] = ram[i];
  end

  always @(posedge clk) begin
    if (memWE) ram[memAddr] <= memData;
    memQ <= ram[memAddr];
  end

  typedef struct {
    int          due;
    bit          b;
    logic [15:0] d;
  } rsp_t;

  rsp_t        sbq[$];
  int          cyc = 0;
  bit          prev_acc = 0, prev_we = 0, last_b = 1;
  logic [11:0] prev_addr = '0;
  logic [15:0] prev_data = '0;
  int          grants_a = 0, grants_b = 0;

  always @(negedge clk) begin
    bit ga, gb, exp_a, exp_b;
    logic [15:0] exp_d;
    rsp_t e;
    cyc++;
    if (!reset) begin
      chk("rst_ready_a", reqAReady, 0);
      chk("rst_ready_b", reqBReady, 0);
      chk("rst_mem_we", memWE, 0);
      chk("rst_resp_a", respAValid, 0);
      chk("rst_resp_b", respBValid, 0);
      sbq.delete();
      prev_acc = 0;
      last_b = 1;
    end else begin
      chk("mem_we", memWE, prev_acc & prev_we);
      if (prev_acc) chk("mem_addr", memAddr, prev_addr);
      if (prev_acc && prev_we) chk("mem_data", memData, prev_data);

      while (sbq.size() > 0 && sbq[0].due < cyc) void'(sbq.pop_front());
      exp_a = 0; exp_b = 0; exp_d = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        exp_a = !e.b; exp_b = e.b; exp_d = e.d;
      end
      chk("resp_valid_a", respAValid, exp_a);
      chk("resp_valid_b", respBValid, exp_b);
      if (exp_a) chk("resp_data_a", respAData, exp_d);
      if (exp_b) chk("resp_data_b", respBData, exp_d);

      ga = reqAValid && (!reqBValid || last_b);
      gb = reqBValid && !ga;
      chk("ready_a", reqAReady, ga);
      chk("ready_b", reqBReady, gb);

      prev_acc = ga || gb;
      if (ga) begin
        prev_we = reqAWrite; prev_addr = reqAAddr; prev_data = reqAData; grants_a++;
      end else if (gb) begin
        prev_we = reqBWrite; prev_addr = reqBAddr; prev_data = reqBData; grants_b++;
      end
      if (prev_acc) begin
        last_b = gb;
        if (prev_we) gold[prev_addr] = prev_data;
        else sbq.push_back('{due: cyc + 2, b: gb, d: gold[prev_addr]});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic cmd(input bit b, input bit wr, input logic [11:0] addr, input logic [15:0] data);
    bit got;
    int n;
    if (!b) begin reqAValid = 1; reqAWrite = wr; reqAAddr = addr; reqAData = data; end
    else    begin reqBValid = 1; reqBWrite = wr; reqBAddr = addr; reqBData = data; end
    got = 0; n = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      got = b ? reqBReady : reqAReady;
      @(posedge clk); #1;
      n++;
    end
    chk("handshake_done", got, 1);
    if (!b) reqAValid = 0; else reqBValid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held from time 0, then idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(4);

    // single read from A
    cmd(0, 0, 12'd1, '0);
    idle(4);

    // continuous contention: both read for 6 cycles
    grants_a = 0; grants_b = 0;
    reqAValid = 1; reqAWrite = 0; reqAAddr = 12'd1;
    reqBValid = 1; reqBWrite = 0; reqBAddr = 12'd512;
    idle(6);
    reqAValid = 0; reqBValid = 0;
    chk("contend_grants_a", grants_a, 3);
    chk("contend_grants_b", grants_b, 3);
    idle(4);

    // A writes addr 1, B reads it the next cycle
    cmd(0, 1, 12'd1, 16'h00A0);
    cmd(1, 0, 12'd1, '0);
    idle(4);
    chk("ram_written", ram[1], 16'h00A0);

    // interleaved mixed traffic with random addresses
    for (int i = 0; i < 12; i++) begin
      cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)),
          16'($urandom));
    end
    idle(4);

    // read in flight, then reset: response must be dropped
    cmd(0, 0, 12'd5, '0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4096; i++) gold[i] = ram[i];
    idle(2);
    cmd(0, 0, 12'd20, '0);
    idle(4);

`ifdef MEM_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) cmd(0, 0, 12'(i), '0);
    for (int i = 0; i < 5; i++) cmd(1, 1, 12'(100 + i), 16'(i));
    idle(2);
    chk("stats_count_a", grantCountA, 16'd3);
    chk("stats_count_b", grantCountB, 16'd5);
    force dut.cnt_a = 16'hFFFF;
    #1 release dut.cnt_a;
    cmd(0, 0, 12'd1, '0);
    idle(2);
    chk("stats_saturate_a", grantCountA, 16'hFFFF);
`endif

    if (sbq.size() != 0) chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
